// File: rtl/ws_feeder_pkg.sv
// Shared types and helpers for the weight-stationary array feeder.
// Holds the sequencer state encoding and the counter-width helper.
package ws_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  // Counter width for a count of n; never narrower than one bit so N=1 still elaborates.
  function automatic int clog2_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws_array_feeder_skew.sv
// Fixed-depth register chain carrying one activation lane plus its valid bit.
// One instance per lane gives the diagonal skew the systolic array expects.
module skew_delay_line #(
  parameter int D_W   = 8,
  parameter int DEPTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D_W-1:0] in_data,
  input  logic           in_valid,
  output logic [D_W-1:0] out_data,
  output logic           out_valid
);

  logic [D_W-1:0]   data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // NOTE: this is a short chain of flops, not a RAM, so clearing every stage on reset is cheap and keeps m0 clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        data_q[s] <= '0;
      end
      valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value, giving a true shift.
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int s = 1; s < DEPTH; s++) begin
        data_q[s]  <= data_q[s-1];
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/ws_array_feeder.sv
// Sequencer feeding a weight-stationary systolic array: loads the weight tile,
// then streams skewed activations and flushes the skew before signalling done.
module ws_array_feeder
  import ws_feeder_pkg::*;
#(
  parameter int D_W = 8,
  parameter int N   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             reuse_w,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [N*D_W-1:0] w_row,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [N*D_W-1:0] a_vec,
  input  logic             a_last,
  output logic             load_weight,
  output logic [N*D_W-1:0] m1,
  output logic [N*D_W-1:0] m0,
  output logic [N-1:0]     row_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = clog2_w(N);
  localparam logic [CW-1:0] WC_LAST = CW'(N - 1);
  localparam logic [CW-1:0] FC_LAST = CW'((N > 1) ? N - 2 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] wc_q, wc_d;
  logic [CW-1:0] fc_q, fc_d;
  logic          w_acc, a_acc;

  assign w_acc = w_valid & w_ready;
  assign a_acc = a_valid & a_ready;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wc_q    <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    state_d = state_q;
    wc_d    = wc_q;
    fc_d    = fc_q;
    w_ready = 1'b0;
    a_ready = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (reuse_w) begin
            state_d = STREAM;
          end else begin
            state_d = LOAD_W;
            wc_d    = '0;
          end
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          wc_d = wc_q + CW'(1);
          if (wc_q == WC_LAST) state_d = STREAM;
        end
      end
      STREAM: begin
        a_ready = 1'b1;
        if (a_valid && a_last) begin
          fc_d    = '0;
          state_d = (N == 1) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        if (fc_q == FC_LAST) state_d = DONE;
        else                 fc_d    = fc_q + CW'(1);
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Weight path: one registered stage; idle cycles drive zero so the array holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_weight <= 1'b0;
      m1          <= '0;
    end else begin
      load_weight <= w_acc;
      m1          <= w_acc ? w_row : '0;
    end
  end

  // Lane i is delayed i+1 cycles; non-accept cycles inject a zero bubble.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [D_W-1:0] lane_in;
    assign lane_in = a_acc ? a_vec[i*D_W +: D_W] : '0;

    skew_delay_line #(
      .D_W  (D_W),
      .DEPTH(i + 1)
    ) u_skew (
      .clk      (clk),
      .rst      (rst),
      .in_data  (lane_in),
      .in_valid (a_acc),
      .out_data (m0[i*D_W +: D_W]),
      .out_valid(row_valid[i])
    );
  end

endmodule

// File: tb/tb_ws_array_feeder.sv
// Scoreboard bench for ws_array_feeder: expected outputs are queued with their
// due cycle when beats are accepted and compared every cycle on the falling edge.
module tb_ws_array_feeder;

  localparam int N   = 4;
  localparam int D_W = 8;
  localparam int W   = N * D_W;

  typedef struct {
    int           cyc;
    logic [W-1:0] data;
  } exp_t;

  logic         clk, rst, start, reuse_w;
  logic         w_valid, w_ready, a_valid, a_ready, a_last;
  logic [W-1:0] w_row, a_vec, m1, m0;
  logic         load_weight, busy, done;
  logic [N-1:0] row_valid;

  ws_array_feeder #(.D_W(D_W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reuse_w    (reuse_w),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_row      (w_row),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_vec      (a_vec),
    .a_last     (a_last),
    .load_weight(load_weight),
    .m1         (m1),
    .m0         (m0),
    .row_valid  (row_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t w_q[$];
  exp_t lane_q[N][$];
  int   done_q[$];
  int   n_checks = 0, n_fail = 0;
  int   load_cnt = 0, done_cnt = 0;
  bit   mon_en = 1'b0, flush_pend = 1'b0;
  int   flush_at = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle monitor: a due entry must appear exactly in its cycle, otherwise zero.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (flush_pend && cyc > flush_at) begin
        w_q.delete();
        for (int i = 0; i < N; i++) lane_q[i].delete();
        done_q.delete();
        flush_pend = 1'b0;
      end
      if (load_weight) load_cnt++;
      if (done) done_cnt++;

      if (w_q.size() > 0 && w_q[0].cyc == cyc) begin
        e = w_q.pop_front();
        check("load_weight", load_weight, 1);
        check("m1", m1, e.data);
      end else begin
        check("load_weight_idle", load_weight, 0);
        check("m1_idle", m1, 0);
      end

      for (int i = 0; i < N; i++) begin
        if (lane_q[i].size() > 0 && lane_q[i][0].cyc == cyc) begin
          e = lane_q[i].pop_front();
          check($sformatf("row_valid[%0d]", i), row_valid[i], 1);
          check($sformatf("m0[%0d]", i), m0[i*D_W +: D_W], e.data[D_W-1:0]);
        end else begin
          check($sformatf("row_valid_idle[%0d]", i), row_valid[i], 0);
          check($sformatf("m0_idle[%0d]", i), m0[i*D_W +: D_W], 0);
        end
      end

      if (done_q.size() > 0 && done_q[0] == cyc) begin
        void'(done_q.pop_front());
        check("done", done, 1);
      end else begin
        check("done_idle", done, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] vec4(input int a, input int b, input int c, input int d);
    return {D_W'(d), D_W'(c), D_W'(b), D_W'(a)};
  endfunction

  task automatic start_tile(input logic reuse);
    start   = 1'b1;
    reuse_w = reuse;
    step();
    start   = 1'b0;
    reuse_w = 1'b0;
  endtask

  task automatic send_w(input logic [W-1:0] row);
    exp_t e;
    int   k = 0;
    w_row   = row;
    w_valid = 1'b1;
    while (!w_ready && k < 50) begin
      step();
      k++;
    end
    check("w_ready_wait", w_ready, 1);
    if (w_ready) begin
      e.cyc  = cyc + 1;
      e.data = row;
      w_q.push_back(e);
    end
    step();
    w_valid = 1'b0;
    w_row   = '0;
  endtask

  task automatic send_a(input logic [W-1:0] vec, input logic last);
    exp_t e;
    int   k = 0;
    a_vec   = vec;
    a_last  = last;
    a_valid = 1'b1;
    while (!a_ready && k < 50) begin
      step();
      k++;
    end
    check("a_ready_wait", a_ready, 1);
    if (a_ready) begin
      for (int i = 0; i < N; i++) begin
        e.cyc  = cyc + 1 + i;
        e.data = W'(vec[i*D_W +: D_W]);
        lane_q[i].push_back(e);
      end
      if (last) done_q.push_back(cyc + N);
    end
    step();
    a_valid = 1'b0;
    a_last  = 1'b0;
    a_vec   = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      step();
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic load_tile(input int base);
    for (int r = 0; r < N; r++) send_w({N{D_W'(base + 8'h11 * r)}});
  endtask

  int lc0, dc0;

  initial begin
    rst = 1'b1; start = 1'b0; reuse_w = 1'b0;
    w_valid = 1'b0; w_row = '0; a_valid = 1'b0; a_vec = '0; a_last = 1'b0;
    idle(2);
    mon_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_done", done, 0);
    check("rst_row_valid", row_valid, 0);
    rst = 1'b0;
    step();

    // Back-to-back weight load, then a two-beat tile.
    lc0 = load_cnt; dc0 = done_cnt;
    start_tile(1'b0);
    check("t1_busy", busy, 1);
    check("t1_w_ready", w_ready, 1);
    load_tile(8'h11);
    check("t1_a_ready", a_ready, 1);
    step();
    check("t1_load_pulses", load_cnt - lc0, 4);
    send_a(vec4(1, 2, 3, 4), 1'b0);
    send_a(vec4(5, 6, 7, 8), 1'b1);
    check("t3_a_ready_after_last", a_ready, 0);
    wait_idle();
    check("t3_done_count", done_cnt - dc0, 1);

    // Weight gap, then a stream with a bubble carrying a stray a_last.
    lc0 = load_cnt; dc0 = done_cnt;
    start_tile(1'b0);
    send_w({N{8'hA1}});
    send_w({N{8'hB2}});
    idle(2);
    check("t2_w_ready_gap", w_ready, 1);
    send_w({N{8'hC3}});
    send_w({N{8'hD4}});
    step();
    check("t2_load_pulses", load_cnt - lc0, 4);
    send_a(vec4(8'h10, 8'h20, 8'h30, 8'h40), 1'b0);
    a_last = 1'b1;
    step();
    a_last = 1'b0;
    check("t4_still_stream", a_ready, 1);
    send_a(vec4(8'h50, 8'h60, 8'h70, 8'h80), 1'b0);
    send_a(vec4(8'hF1, 8'hF2, 8'hF3, 8'hF4), 1'b1);
    wait_idle();
    check("t4_done_count", done_cnt - dc0, 1);

    // Weight reuse; start while busy must be ignored; then a back-to-back tile.
    lc0 = load_cnt; dc0 = done_cnt;
    start_tile(1'b1);
    check("t5_a_ready", a_ready, 1);
    check("t5_w_ready", w_ready, 0);
    send_a(vec4(9, 10, 11, 12), 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    send_a(vec4(13, 14, 15, 16), 1'b1);
    wait_idle();
    start_tile(1'b1);
    send_a(vec4(8'hEE, 8'hDD, 8'hCC, 8'hBB), 1'b1);
    wait_idle();
    step();
    check("t5_no_load", load_cnt - lc0, 0);
    check("t5_done_count", done_cnt - dc0, 2);

    // Reset in the middle of a stream.
    dc0 = done_cnt;
    start_tile(1'b0);
    load_tile(8'h05);
    send_a(vec4(1, 1, 1, 1), 1'b0);
    send_a(vec4(2, 2, 2, 2), 1'b0);
    rst        = 1'b1;
    flush_at   = cyc;
    flush_pend = 1'b1;
    step();
    check("t6_busy", busy, 0);
    check("t6_a_ready", a_ready, 0);
    check("t6_row_valid", row_valid, 0);
    check("t6_m0", m0, 0);
    check("t6_done", done, 0);
    rst = 1'b0;
    idle(6);
    check("t6_no_done", done_cnt - dc0, 0);
    start_tile(1'b0);
    load_tile(8'h21);
    send_a(vec4(3, 4, 5, 6), 1'b1);
    wait_idle();
    check("t6_fresh_done", done_cnt - dc0, 1);

    idle(8);
    check("sb_w_empty", w_q.size(), 0);
    check("sb_done_empty", done_q.size(), 0);
    for (int i = 0; i < N; i++) check($sformatf("sb_lane%0d_empty", i), lane_q[i].size(), 0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
